// File: rtl/booth_seq_divider_if.sv
// Handshake and operand/result bundle for booth_seq_divider.
// The requester uses the master modport and the divider uses the slave modport.
interface booth_seq_divider_if #(
  parameter int DATAWIDTH = 8
);
  logic                     START;
  logic [2*DATAWIDTH-1:0]   DIVIDEND;
  logic [DATAWIDTH-1:0]     DIVISOR;
  logic [DATAWIDTH-1:0]     QUOTIENT;
  logic [DATAWIDTH-1:0]     REMAINDER;
  logic                     BUSY;
  logic                     Done;
  logic                     DIV0;
  logic                     OVF;

  modport master (
    output START, DIVIDEND, DIVISOR,
    input  QUOTIENT, REMAINDER, BUSY, Done, DIV0, OVF
  );

  modport slave (
    input  START, DIVIDEND, DIVISOR,
    output QUOTIENT, REMAINDER, BUSY, Done, DIV0, OVF
  );
endinterface

// File: rtl/booth_seq_divider.sv
// Sequential radix-2 restoring divider: 2W-bit dividend / W-bit divisor.
// It produces one quotient bit per cycle. The fixed flow is IDLE -> PREP -> ITER (W cycles) -> FIX.
// Optional feature macro: DIV_SIGNED_EN (two's-complement operands/results).
// When the macro is undefined, the divider is purely unsigned.
module booth_seq_divider #(
  parameter int DATAWIDTH = 8
) (
  input logic               CLK,
  input logic               RST,
  booth_seq_divider_if.slave bus
);
  localparam int W  = DATAWIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
`ifdef DIV_SIGNED_EN
  localparam logic [W-1:0] Q_MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] Q_MAX_NEG = {1'b1, {(W-1){1'b0}}};
`endif

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER, S_FIX} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]  dvd_q, dvd_d;      // raw dividend, kept for the DIV0 remainder
  logic [W-1:0]    dvs_q, dvs_d;      // raw divisor, replaced by its magnitude in PREP
  logic [W-1:0]    rem_q, rem_d;      // partial remainder
  logic [W-1:0]    shf_q, shf_d;      // low dividend bits shift out, quotient bits shift in
  logic            div0_q, div0_d;    // divisor magnitude was zero
  logic            povf_q, povf_d;    // quotient cannot fit before iterating
`ifdef DIV_SIGNED_EN
  logic            qneg_q, qneg_d;    // quotient negative (operand signs differ)
  logic            rneg_q, rneg_d;    // remainder takes the dividend sign
`endif
  logic [W-1:0]    quot_q, quot_d;
  logic [W-1:0]    remo_q, remo_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            div0o_q, div0o_d;
  logic            ovf_q, ovf_d;

  // Datapath temporaries
  logic [2*W-1:0]  dvd_mag;
  logic [W-1:0]    dvs_mag;
  logic [W:0]      r_sh;
  logic [W-1:0]    q_mag;
  logic            ovf_any;

  // Next-state and datapath logic for every register
  always_comb begin
    // NOTE: every variable gets a default here, so no path through the case leaves one unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    shf_d   = shf_q;
    div0_d  = div0_q;
    povf_d  = povf_q;
`ifdef DIV_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    quot_d  = quot_q;
    remo_d  = remo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    div0o_d = div0o_q;
    ovf_d   = ovf_q;
    dvd_mag = dvd_q;
    dvs_mag = dvs_q;
    r_sh    = {rem_q, shf_q[W-1]};
    q_mag   = shf_q;
    ovf_any = povf_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          dvd_d   = bus.DIVIDEND;
          dvs_d   = bus.DIVISOR;
          busy_d  = 1'b1;
          state_d = S_PREP;
        end
      end

      S_PREP: begin
`ifdef DIV_SIGNED_EN
        // Unsigned 2W/W-bit negation is exact for the most negative value (2^(2W-1), 2^(W-1)), so nothing wraps.
        dvd_mag = dvd_q[2*W-1] ? -dvd_q : dvd_q;
        dvs_mag = dvs_q[W-1]   ? -dvs_q : dvs_q;
        rneg_d  = dvd_q[2*W-1];
        qneg_d  = dvd_q[2*W-1] ^ dvs_q[W-1];
`endif
        dvs_d   = dvs_mag;
        div0_d  = (dvs_mag == '0);
        povf_d  = (dvd_mag[2*W-1:W] >= dvs_mag);
        rem_d   = dvd_mag[2*W-1:W];
        shf_d   = dvd_mag[W-1:0];
        cnt_d   = '0;
        state_d = S_ITER;
      end

      S_ITER: begin
        // Iterations always run, even when a flag is set, so the latency stays fixed.
        if (r_sh >= {1'b0, dvs_q}) begin
          rem_d = r_sh[W-1:0] - dvs_q;
          shf_d = {shf_q[W-2:0], 1'b1};
        end else begin
          rem_d = r_sh[W-1:0];
          shf_d = {shf_q[W-2:0], 1'b0};
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end

      S_FIX: begin
`ifdef DIV_SIGNED_EN
        ovf_any = povf_q | (qneg_q ? (q_mag > Q_MAX_NEG) : (q_mag > Q_MAX_POS));
`endif
        if (div0_q) begin
          quot_d  = '1;
          remo_d  = dvd_q[W-1:0];
          div0o_d = 1'b1;
          ovf_d   = 1'b0;
        end else if (ovf_any) begin
          quot_d  = '0;
          remo_d  = '0;
          div0o_d = 1'b0;
          ovf_d   = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
          quot_d  = qneg_q ? -q_mag : q_mag;
          remo_d  = rneg_q ? -rem_q : rem_q;
`else
          quot_d  = q_mag;
          remo_d  = rem_q;
`endif
          div0o_d = 1'b0;
          ovf_d   = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State register: asynchronous reset aborts any operation immediately
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: datapath registers are reset too, so reset leaves every internal register at zero.
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      shf_q   <= '0;
      div0_q  <= 1'b0;
      povf_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
      quot_q  <= '0;
      remo_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0o_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value of every other flop.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      shf_q   <= shf_d;
      div0_q  <= div0_d;
      povf_q  <= povf_d;
`ifdef DIV_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      div0o_q <= div0o_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.QUOTIENT  = quot_q;
  assign bus.REMAINDER = remo_q;
  assign bus.BUSY      = busy_q;
  assign bus.Done      = done_q;
  assign bus.DIV0      = div0o_q;
  assign bus.OVF       = ovf_q;

endmodule

// File: tb/tb_booth_seq_divider.sv
// Scoreboard bench for booth_seq_divider (W=8).
// Stimulus pushes the expected results and the Done cycle into a queue.
// A monitor pops from the queue and compares on every Done pulse.
module tb_booth_seq_divider;
  localparam int W   = 8;
  localparam int LAT = W + 2;   // Done is seen after edge E0+LAT

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         div0;
    logic         ovf;
    int           done_cyc;
    string        name;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  booth_seq_divider_if #(.DATAWIDTH(W)) bus ();

  booth_seq_divider #(.DATAWIDTH(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Caller is at a negedge; START is sampled at the next posedge (E0)
  task automatic issue(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                       input logic [W-1:0] q, input logic [W-1:0] r,
                       input logic d0, input logic ov, input string name);
    exp_t e;
    e.q = q; e.r = r; e.div0 = d0; e.ovf = ov; e.name = name;
    e.done_cyc = cyc + 1 + LAT;
    sb.push_back(e);
    bus.START    = 1'b1;
    bus.DIVIDEND = dvd;
    bus.DIVISOR  = dvs;
    @(posedge CLK);
    @(negedge CLK);
    bus.START = 1'b0;
  endtask

  // Returns at the negedge where Done is high, or flags a timeout
  task automatic wait_done(input string name);
    int n = 0;
    while (!bus.Done && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check({name, "_timeout"}, {31'd0, bus.Done}, 32'd1);
  endtask

  task automatic run(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                     input logic [W-1:0] q, input logic [W-1:0] r,
                     input logic d0, input logic ov, input string name);
    issue(dvd, dvs, q, r, d0, ov, name);
    wait_done(name);
    @(negedge CLK);
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_Q"},    {24'd0, bus.QUOTIENT},  32'd0);
    check({name, "_R"},    {24'd0, bus.REMAINDER}, 32'd0);
    check({name, "_BUSY"}, {31'd0, bus.BUSY},      32'd0);
    check({name, "_Done"}, {31'd0, bus.Done},      32'd0);
    check({name, "_DIV0"}, {31'd0, bus.DIV0},      32'd0);
    check({name, "_OVF"},  {31'd0, bus.OVF},       32'd0);
  endtask

  // Monitor: every Done pulse must match the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (bus.Done) begin
        if (sb.size() == 0) begin
          check("unexpected_Done", {31'd0, bus.Done}, 32'd0);
        end else begin
          e = sb.pop_front();
          check({e.name, "_Q"},    {24'd0, bus.QUOTIENT},  {24'd0, e.q});
          check({e.name, "_R"},    {24'd0, bus.REMAINDER}, {24'd0, e.r});
          check({e.name, "_DIV0"}, {31'd0, bus.DIV0},      {31'd0, e.div0});
          check({e.name, "_OVF"},  {31'd0, bus.OVF},       {31'd0, e.ovf});
          check({e.name, "_BUSY"}, {31'd0, bus.BUSY},      32'd0);
          check({e.name, "_cycle"}, cyc,                   e.done_cyc);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.START    = 1'b0;
    bus.DIVIDEND = '0;
    bus.DIVISOR  = '0;
    #12;
    check_zero_outputs("reset");
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

`ifdef DIV_SIGNED_EN
    run(16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, "s_100_7");
    run(16'hFF9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0, "s_m100_7");
    run(16'h0064, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0, "s_100_m7");
    run(16'hFF9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0, "s_m100_m7");
    run(16'h4000, 8'h80, 8'h80, 8'h00, 1'b0, 1'b0, "s_16384_m128");
    run(16'hC000, 8'h80, 8'h00, 8'h00, 1'b0, 1'b1, "s_m16384_m128");
    run(16'h03E8, 8'h07, 8'h00, 8'h00, 1'b0, 1'b1, "s_1000_7");
    run(16'hFF80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, "s_m128_1");
    run(16'h0080, 8'h01, 8'h00, 8'h00, 1'b0, 1'b1, "s_128_1");
    run(16'h8000, 8'h01, 8'h00, 8'h00, 1'b0, 1'b1, "s_minint_1");
`else
    run(16'hFE01, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, "u_FE01_FF");
    run(16'hFF00, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1, "u_FF00_FF");
    run(16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, "u_100_7");
    run(16'h03E8, 8'h07, 8'h8E, 8'h06, 1'b0, 1'b0, "u_1000_7");
    run(16'h00FF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, "u_00FF_1");
    run(16'h0100, 8'h01, 8'h00, 8'h00, 1'b0, 1'b1, "u_0100_1");
    run(16'h0000, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, "u_0_1");
`endif
    // Divide by zero (same in both builds)
    run(16'h1234, 8'h00, 8'hFF, 8'h34, 1'b1, 1'b0, "div0");

    // START while BUSY is ignored: only the first operation completes
    run(16'h0029, 8'h05, 8'h08, 8'h01, 1'b0, 1'b0, "pre_busy");
    issue(16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, "busy_ign");
    @(negedge CLK);
    check("busy_high", {31'd0, bus.BUSY}, 32'd1);
    bus.START    = 1'b1;
    bus.DIVIDEND = 16'h1234;
    bus.DIVISOR  = 8'h00;
    @(negedge CLK);
    bus.START = 1'b0;
    wait_done("busy_ign");

    // Back-to-back: START in the Done cycle is accepted
    issue(16'h0029, 8'h05, 8'h08, 8'h01, 1'b0, 1'b0, "b2b");
    wait_done("b2b");
    @(negedge CLK);

    // Reset mid-operation: outputs clear, no Done, next operation is normal
    issue(16'h1234, 8'h00, 8'hFF, 8'h34, 1'b1, 1'b0, "dummy");
    void'(sb.pop_back());          // this operation is aborted and never completes
    repeat (4) @(posedge CLK);
    #1 RST = 1'b1;
    #2 check_zero_outputs("rst_mid");
    @(negedge CLK);
    RST = 1'b0;
    repeat (12) @(negedge CLK);
    check("rst_no_done_busy", {31'd0, bus.BUSY}, 32'd0);
    run(16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, "after_rst");

    repeat (5) @(negedge CLK);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
